// File: rtl/keypad_bcd_entry_pkg.sv
// Shared types and constants for the keypad BCD entry block.
package keypad_bcd_entry_pkg;

    localparam int BCD_W = 4;
    localparam int KEY_N = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_HELD  = 2'd2,
        S_REL   = 2'd3
    } state_t;

    // Keypad line to BCD digit: line 0 is digit 0, line i (i>=1) is digit 10-i.
    function automatic logic [BCD_W-1:0] line_to_bcd(input int idx);
        return (idx == 0) ? '0 : BCD_W'(10 - idx);
    endfunction

endpackage

// File: rtl/keypad_bcd_entry_prio_enc.sv
// Combinational 10-line to BCD priority encoder; highest active line wins.
module key_prio_enc
    import keypad_bcd_entry_pkg::*;
(
    input  logic [KEY_N-1:0] lines,
    output logic [BCD_W-1:0] code,
    output logic             any
);

    // Ascending scan so the highest active line is written last and wins.
    always_comb begin
        code = '0;
        any  = |lines;
        for (int i = 0; i < KEY_N; i++) begin
            if (lines[i]) begin
                code = line_to_bcd(i);
            end
        end
    end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Keypad sampler: synchroniser, debounce FSM and calculator-style BCD entry register.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no key down, waiting for any line
//   S_PRESS | key seen, counting stable cycles of the same code
//   S_HELD  | key accepted, waiting for release (never re-accepts)
//   S_REL   | lines dropped, counting stable released cycles
//
// The debounce timer is a down-counter: it loads DEB_CYC-1 on the first
// stable cycle and the terminal count (zero) marks DEB_CYC stable cycles.
module keypad_bcd_entry
    import keypad_bcd_entry_pkg::*;
#(
    parameter  int NDIG    = 2,
    parameter  int DEB_CYC = 4,
    localparam int CW      = $clog2(NDIG + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_N-1:0]    dig,
    input  logic                clr,
    output logic [BCD_W*NDIG-1:0] bcd,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                ovf,
    output logic                key_valid,
    output logic [BCD_W-1:0]    key_code
);

    localparam int            DW       = $clog2(DEB_CYC + 1);
    localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NDIG);

    logic [KEY_N-1:0]      sync1;
    logic [KEY_N-1:0]      sd;
    logic [BCD_W-1:0]      enc_code;
    logic                  enc_any;
    state_t                state, state_next;
    logic [DW-1:0]         rem, rem_next;
    logic [BCD_W-1:0]      code_q, code_next;
    logic                  accept;
    logic [BCD_W*NDIG-1:0] shifted;

    // Two-flop synchroniser for the asynchronous keypad lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sd    <= '0;
        end else begin
            sync1 <= dig;
            sd    <= sync1;
        end
    end

    key_prio_enc u_enc (
        .lines (sd),
        .code  (enc_code),
        .any   (enc_any)
    );

    // FSM state, debounce timer and latched candidate code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            rem    <= '0;
            code_q <= '0;
        end else begin
            state  <= state_next;
            rem    <= rem_next;
            code_q <= code_next;
        end
    end

    // Debounce next-state logic; a code change mid-press restarts the timer.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        code_next  = code_q;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enc_any) begin
                    state_next = S_PRESS;
                    rem_next   = DEB_LOAD;
                    code_next  = enc_code;
                end
            end
            S_PRESS: begin
                if (!enc_any) begin
                    state_next = S_IDLE;
                end else if (enc_code != code_q) begin
                    code_next = enc_code;
                    rem_next  = DEB_LOAD;
                end else if (rem == '0) begin
                    accept     = 1'b1;
                    state_next = S_HELD;
                end else begin
                    rem_next = rem - DW'(1);
                end
            end
            S_HELD: begin
                if (!enc_any) begin
                    state_next = S_REL;
                    rem_next   = DEB_LOAD;
                end
            end
            S_REL: begin
                if (enc_any) begin
                    state_next = S_HELD;
                end else if (rem == '0) begin
                    state_next = S_IDLE;
                end else begin
                    rem_next = rem - DW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    generate
        if (NDIG == 1) begin : g_one
            assign shifted = code_q;
        end else begin : g_many
            assign shifted = {bcd[BCD_W*NDIG-BCD_W-1:0], code_q};
        end
    endgenerate

    // Entry register: shift in accepted digits, flag overflow when full; clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd       <= '0;
            count     <= '0;
            full      <= 1'b0;
            ovf       <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= 1'b0;
            if (accept) begin
                key_code <= code_q;
            end
            if (clr) begin
                bcd   <= '0;
                count <= '0;
                full  <= 1'b0;
                ovf   <= 1'b0;
            end else if (accept) begin
                if (count == CNT_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    bcd       <= shifted;
                    count     <= count + CW'(1);
                    full      <= (count == CNT_MAX - CW'(1));
                    key_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry with an accept scoreboard (NDIG=2, DEB_CYC=4).
module tb_keypad_bcd_entry;

    localparam int NDIG = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] dig = '0;
    logic       clr = 1'b0;
    logic [7:0] bcd;
    logic [1:0] count;
    logic       full, ovf, key_valid;
    logic [3:0] key_code;

    typedef struct {
        logic [7:0] bcd;
        int         count;
        logic [3:0] code;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int n_cmp  = 0;
    int n_err  = 0;
    int kv_cnt = 0;
    int cyc    = 0;

    logic [7:0] m_bcd  = '0;
    int         m_cnt  = 0;
    logic       m_ovf  = 1'b0;
    logic [3:0] m_code = '0;

    keypad_bcd_entry #(.NDIG(NDIG), .DEB_CYC(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .dig       (dig),
        .clr       (clr),
        .bcd       (bcd),
        .count     (count),
        .full      (full),
        .ovf       (ovf),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every key_valid pulse pops one expected accept.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (key_valid === 1'b1) begin
            kv_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL kv_unexpected: observed key_valid with bcd %0h, expected no accept", bcd);
            end else begin
                e = sb.pop_front();
                chk("sb_bcd", 32'(bcd), 32'(e.bcd));
                chk("sb_count", 32'(count), 32'(e.count));
                chk("sb_code", 32'(key_code), 32'(e.code));
                chk("sb_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic model_accept(input logic [3:0] code, input int ecyc);
        exp_t e;
        m_code = code;
        if (m_cnt < NDIG) begin
            m_bcd = {m_bcd[3:0], code};
            m_cnt++;
            e.bcd   = m_bcd;
            e.count = m_cnt;
            e.code  = code;
            e.cyc   = ecyc;
            sb.push_back(e);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_clr();
        m_bcd = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_bcd"}, 32'(bcd), 32'(m_bcd));
        chk({tag, "_count"}, 32'(count), 32'(m_cnt));
        chk({tag, "_full"}, 32'(full), 32'(m_cnt == NDIG));
        chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, "_code"}, 32'(key_code), 32'(m_code));
        chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bcd"}, 32'(bcd), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_kv"}, 32'(key_valid), 32'd0);
        chk({tag, "_code"}, 32'(key_code), 32'd0);
    endtask

    // Called just after a falling edge: key down for 'hold' cycles then released.
    task automatic press(input logic [9:0] d, input logic [3:0] code, input int hold);
        dig = d;
        model_accept(code, cyc + 1 + 2 + DEB);
        repeat (hold) @(negedge clk);
        dig = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clr();
        @(negedge clk);
    endtask

    initial begin : stim
        int kv0;
        int c0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single key, latency and first digit
        kv0 = kv_cnt;
        press(10'h200, 4'd1, 10);
        chk("t1_pulses", 32'(kv_cnt - kv0), 32'd1);
        check_state("t1");

        // 2: fill the register, then overflow
        do_clr();
        check_state("t2_clr");
        press(10'h040, 4'd4, 10);
        press(10'h008, 4'd7, 10);
        check_state("t2_full");
        kv0 = kv_cnt;
        press(10'h080, 4'd3, 10);
        chk("t2_ovf_pulses", 32'(kv_cnt - kv0), 32'd0);
        check_state("t2_ovf");

        // 3: press bounce, then release bounce during hold
        do_clr();
        kv0 = kv_cnt;
        for (int i = 0; i < 3; i++) begin
            dig = 10'h020;
            repeat (3) @(negedge clk);
            dig = '0;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("t3_bounce_pulses", 32'(kv_cnt - kv0), 32'd0);
        dig = 10'h020;
        model_accept(4'd5, cyc + 1 + 2 + DEB);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            dig = '0;
            repeat (2) @(negedge clk);
            dig = 10'h020;
            repeat (3) @(negedge clk);
        end
        dig = '0;
        repeat (12) @(negedge clk);
        chk("t3_hold_pulses", 32'(kv_cnt - kv0), 32'd1);
        check_state("t3");

        // 4: multi-line priority with long hold, then mid-press key switch
        do_clr();
        kv0 = kv_cnt;
        press(10'h202, 4'd1, 100);
        chk("t4_long_pulses", 32'(kv_cnt - kv0), 32'd1);
        dig = 10'h010;
        repeat (3) @(negedge clk);
        press(10'h004, 4'd8, 10);
        chk("t4_switch_pulses", 32'(kv_cnt - kv0), 32'd2);
        check_state("t4");

        // 5: overflow, then clr coinciding with an accept
        press(10'h002, 4'd9, 10);
        check_state("t5_ovf");
        kv0 = kv_cnt;
        dig = 10'h001;
        c0 = cyc;
        repeat (6) @(negedge clk);
        chk("t5_pre_cyc", 32'(cyc), 32'(c0 + 6));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5_kv", 32'(key_valid), 32'd0);
        chk("t5_bcd", 32'(bcd), 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_full", 32'(full), 32'd0);
        model_clr();
        repeat (10) @(negedge clk);
        dig = '0;
        repeat (12) @(negedge clk);
        chk("t5_pulses", 32'(kv_cnt - kv0), 32'd0);
        press(10'h001, 4'd0, 10);
        check_state("t5_zero_digit");

        // 6: reset during press and during hold
        press(10'h100, 4'd2, 10);
        check_state("t6_pre");
        dig = 10'h080;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("t6_rst_press");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clr();
        m_code = '0;
        kv0 = kv_cnt;
        model_accept(4'd3, cyc + 1 + 2 + DEB);
        repeat (15) @(negedge clk);
        chk("t6_press_pulses", 32'(kv_cnt - kv0), 32'd1);
        check_state("t6_after_press");
        #2 rst = 1'b1;
        #1 check_zero("t6_rst_held");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clr();
        m_code = '0;
        model_accept(4'd3, cyc + 1 + 2 + DEB);
        repeat (15) @(negedge clk);
        dig = '0;
        repeat (12) @(negedge clk);
        chk("t6_held_pulses", 32'(kv_cnt - kv0), 32'd2);
        check_state("t6_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
